vslc_executor_p: RTL and testbench

- Parametrised next-generation VSLC bit-stack executor. Consumes 8-bit instructions through a valid/ready handshake and evaluates boolean logic on a bit stack against the input pins.
- Drives output pins, NUM_TIMERS timer channels and a 16-bit SFR.
- Adds over the previous generation: stack depth tracking with sticky overflow/underflow flags, latched input edges, guaranteed parameter-byte consumption, and a timer count set by parameter.
- Sits between the instruction fetcher and the top-level pins.

---
 rtl/vslc_pkg.sv | 43 ++++
 rtl/vslc_timer_ch.sv | 49 ++++
 rtl/vslc_executor_p.sv | 211 +++++++++++++++++++++
 tb/tb_vslc_executor_p.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared constants and types for the VSLC bit-stack executor.
// Holds opcode fields, SFR bit positions, timer reset defaults and FSM states.
package vslc_pkg;

    typedef enum logic {EXEC = 1'b0, PARAM = 1'b1} state_t;

    // Opcode prefixes; register ops are any byte with bit7 clear
    localparam logic [1:0] PFX_LOGIC  = 2'b10;
    localparam logic [2:0] PFX_TEMP   = 3'b110;
    localparam logic [3:0] PFX_SPARAM = 4'b1110;
    localparam logic [3:0] PFX_STACK  = 4'b1111;

    localparam logic [1:0] REG_PUSH = 2'b00;
    localparam logic [1:0] REG_POP  = 2'b01;
    localparam logic [1:0] REG_SET  = 2'b10;
    localparam logic [1:0] REG_RST  = 2'b11;

    localparam logic [1:0] LOG_TOS  = 2'b00;
    localparam logic [1:0] LOG_POP2 = 2'b01;
    localparam logic [1:0] LOG_NOP  = 2'b10;
    localparam logic [1:0] LOG_PUSH = 2'b11;

    localparam logic [3:0] STK_CLR    = 4'h0;
    localparam logic [3:0] STK_SETALL = 4'h1;
    localparam logic [3:0] STK_SWAP   = 4'h2;
    localparam logic [3:0] STK_ROT    = 4'h3;

    localparam int SFR_OVF   = 8;
    localparam int SFR_UNF   = 9;
    localparam int SFR_PEND  = 10;
    localparam int SFR_ROUTE = 12;

    localparam logic [3:0] DIV_RST    = 4'd14;
    localparam logic [7:0] PERIOD_RST = 8'd183;

    // Parameter-byte write strobe for one timer channel
    typedef struct packed {
        logic       div_we;
        logic       per_we;
        logic [7:0] data;
    } tmr_wr_t;

endpackage

// File: rtl/vslc_timer_ch.sv
// One timer channel: prescaler-derived tick, period counter and toggling output.
// div/period are loaded from parameter bytes routed in by the executor.
module vslc_timer_ch
    import vslc_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescaler,
    input  logic                  en,
    input  tmr_wr_t               wr,
    output logic                  tout
);

    logic [3:0] div_q;
    logic [7:0] period_q;
    logic [7:0] count_q;
    logic       tick;

    // Tick when the low div bits of the prescaler are all zero
    always_comb begin
        tick = 1'b1;
        for (int b = 0; b < PRESCALE_W; b++) begin
            if (b < int'(div_q) && prescaler[b]) tick = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= DIV_RST;
            period_q <= PERIOD_RST;
            count_q  <= '0;
            tout     <= 1'b0;
        end else begin
            if (wr.div_we) div_q <= wr.data[3:0];
            if (wr.per_we) period_q <= wr.data;
            if (en && tick) begin
                if (count_q == period_q) begin
                    tout    <= ~tout;
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vslc_executor_p.sv
// VSLC bit-stack executor: byte-stream instruction decode, bit stack with depth
// tracking, latched input edges, output/SFR registers and NUM_TIMERS timer channels.
module vslc_executor_p
    import vslc_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int NUM_TIMERS  = 2,
    parameter int PRESCALE_W  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [7:0]                         instr,
    input  logic [IN_W-1:0]                    ui_in,
    output logic [OUT_W-1:0]                   uo_out,
    output logic [15:0]                        sfr_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               tos_out
);

    localparam int DW = $clog2(STACK_DEPTH+1);

    state_t                  state_q, state_d;
    logic                    cond_q, cond_d;
    logic [2:0]              pidx_q, pidx_d;
    logic [STACK_DEPTH-1:0]  stack_q, stack_d;
    logic [DW-1:0]           depth_q, depth_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic [15:0]             sfr_q, sfr_d, sfr_img;
    logic [IN_W-1:0]         rise_q, fall_q, ui_prev;
    logic [PRESCALE_W-1:0]   presc_q;

    logic [NUM_TIMERS-1:0]            tout;
    tmr_wr_t [NUM_TIMERS-1:0]         tmr_wr;

    logic       accept, tos, r, rd, we, wv, ovf, unf, push_en, push_v;
    logic [1:0] pop_n;
    logic [7:0] out_w, out_pad, in_pad, rise_pad, fall_pad, rclr, fclr;

    assign accept      = instr_valid && instr_ready;
    assign tos         = stack_q[0];
    assign tos_out     = stack_q[0];
    assign stack_depth = depth_q;
    assign sfr_out     = sfr_img;
    assign out_pad     = 8'(out_q);
    assign in_pad      = 8'(ui_in);
    assign rise_pad    = 8'(rise_q);
    assign fall_pad    = 8'(fall_q);

    // Hardware-owned bits overlay the stored register image
    always_comb begin
        sfr_img = sfr_q;
        for (int k = 0; k < NUM_TIMERS; k++) sfr_img[2*k+1] = tout[k];
        sfr_img[SFR_PEND] = (state_q == PARAM);
    end

    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        pidx_d  = pidx_q;
        stack_d = stack_q;
        depth_d = depth_q;
        sfr_d   = sfr_q;
        out_w   = out_pad;
        tmr_wr  = '0;
        rclr    = '0;
        fclr    = '0;
        pop_n   = 2'd0;
        push_en = 1'b0;
        push_v  = 1'b0;
        ovf     = 1'b0;
        unf     = 1'b0;
        we      = 1'b0;
        wv      = 1'b0;
        rd      = 1'b0;
        // tttt is a truth table indexed by {nos,tos}
        r       = instr[stack_q[1:0]];

        if (accept) begin
            if (state_q == PARAM) begin
                state_d = EXEC;
                if (cond_q) begin
                    for (int k = 0; k < NUM_TIMERS; k++) begin
                        if (pidx_q[2:1] == 2'(k)) begin
                            tmr_wr[k].div_we = ~pidx_q[0];
                            tmr_wr[k].per_we = pidx_q[0];
                            tmr_wr[k].data   = instr;
                        end
                    end
                end
            end else if (!instr[7]) begin
                if (instr[6])      rd = sfr_img[instr[3:0]];
                else if (instr[3]) rd = out_pad[instr[2:0]];
                else               rd = in_pad[instr[2:0]];
                case (instr[5:4])
                    REG_PUSH: begin push_en = 1'b1; push_v = rd; end
                    REG_POP:  begin pop_n = 2'd1; we = 1'b1; wv = tos; end
                    REG_SET:  begin pop_n = 2'd1; we = tos; wv = 1'b1; end
                    default:  begin pop_n = 2'd1; we = tos; wv = 1'b0; end
                endcase
                if (we) begin
                    if (instr[6]) sfr_d[instr[3:0]] = wv;
                    else          out_w[instr[2:0]] = wv;
                end
            end else if (instr[7:6] == PFX_LOGIC) begin
                case (instr[5:4])
                    LOG_TOS:  stack_d[0] = r;
                    LOG_POP2: begin pop_n = 2'd2; push_en = 1'b1; push_v = r; end
                    LOG_PUSH: begin push_en = 1'b1; push_v = r; end
                    default:  ;
                endcase
            end else if (instr[7:5] == PFX_TEMP) begin
                push_en = 1'b1;
                push_v  = instr[4] ? fall_pad[instr[2:0]] : rise_pad[instr[2:0]];
                rclr[instr[2:0]] = ~instr[4];
                fclr[instr[2:0]] = instr[4];
            end else if (instr[7:4] == PFX_SPARAM) begin
                state_d = PARAM;
                cond_d  = (tos == instr[3]);
                pidx_d  = instr[2:0];
            end else begin
                case (instr[3:0])
                    STK_CLR:    begin stack_d = '0; depth_d = '0; end
                    STK_SETALL: begin stack_d = '1; depth_d = DW'(STACK_DEPTH); end
                    STK_SWAP:   begin stack_d[0] = stack_q[1]; stack_d[1] = stack_q[0]; end
                    STK_ROT: begin
                        stack_d[0] = stack_q[1];
                        stack_d[1] = stack_q[2];
                        stack_d[2] = stack_q[0];
                    end
                    default: ;
                endcase
            end
        end

        // Pops happen before the push so pop-two-push-one nets a single pop
        if (pop_n != 2'd0 || push_en) begin
            stack_d = stack_q >> pop_n;
            if (depth_q < DW'(pop_n)) begin
                unf     = 1'b1;
                depth_d = '0;
            end else begin
                depth_d = depth_q - DW'(pop_n);
            end
            if (push_en) begin
                stack_d = {stack_d[STACK_DEPTH-2:0], push_v};
                if (depth_d == DW'(STACK_DEPTH)) ovf = 1'b1;
                else                             depth_d = depth_d + DW'(1);
            end
        end
        if (ovf) sfr_d[SFR_OVF] = 1'b1;
        if (unf) sfr_d[SFR_UNF] = 1'b1;
        out_d = out_w[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EXEC;
            cond_q      <= 1'b0;
            pidx_q      <= '0;
            stack_q     <= '0;
            depth_q     <= '0;
            out_q       <= '0;
            sfr_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            ui_prev     <= '0;
            presc_q     <= '0;
            instr_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            pidx_q      <= pidx_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            out_q       <= out_d;
            sfr_q       <= sfr_d;
            // A new edge beats a same-cycle clear
            rise_q      <= (rise_q & ~rclr[IN_W-1:0]) | (ui_in & ~ui_prev);
            fall_q      <= (fall_q & ~fclr[IN_W-1:0]) | (~ui_in & ui_prev);
            ui_prev     <= ui_in;
            presc_q     <= presc_q + PRESCALE_W'(1);
            instr_ready <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
        vslc_timer_ch #(.PRESCALE_W(PRESCALE_W)) u_tmr (
            .clk       (clk),
            .rst_n     (rst_n),
            .prescaler (presc_q),
            .en        (sfr_q[2*k]),
            .wr        (tmr_wr[k]),
            .tout      (tout[k])
        );
    end

    // Timer k may take over output pin OUT_W-1-k
    for (genvar j = 0; j < OUT_W; j++) begin : g_pin
        localparam int K = OUT_W - 1 - j;
        if (K < NUM_TIMERS) begin : g_route
            assign uo_out[j] = sfr_q[SFR_ROUTE+K] ? tout[K] : out_q[j];
        end else begin : g_plain
            assign uo_out[j] = out_q[j];
        end
    end

endmodule

// File: tb/tb_vslc_executor_p.sv
// Directed bench for vslc_executor_p: stack/logic ops, depth flags, edges,
// conditional parameter writes and timer routing.
module tb_vslc_executor_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [7:0]  instr = 8'h00;
    logic [7:0]  ui_in = 8'h00;
    logic        instr_ready;
    logic [7:0]  uo_out;
    logic [15:0] sfr_out;
    logic [3:0]  stack_depth;
    logic        tos_out;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    vslc_executor_p dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ui_in       (ui_in),
        .uo_out      (uo_out),
        .sfr_out     (sfr_out),
        .stack_depth (stack_depth),
        .tos_out     (tos_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        instr       = b;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Cycles between two consecutive toggles of uo_out[pin]; bounded
    task automatic measure(input int pin, output int cnt);
        logic v;
        int   t;
        cnt = 0;
        t   = 0;
        @(negedge clk);
        v = uo_out[pin];
        while (uo_out[pin] == v && t < 100) begin @(negedge clk); t++; end
        v = uo_out[pin];
        while (uo_out[pin] == v && t < 200) begin @(negedge clk); t++; cnt++; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_uo", uo_out, 0);
        check("rst_sfr", sfr_out, 0);
        check("rst_depth", stack_depth, 0);
        check("rst_tos", tos_out, 0);
        check("rst_ready", instr_ready, 0);
        rst_n = 1'b1;
        check("ready_at_release", instr_ready, 0);
        @(negedge clk);
        check("ready_after", instr_ready, 1);
        send(8'hA0);
        check("nop_pend", sfr_out[10], 0);
        check("nop_depth", stack_depth, 0);

        // push in0, push in2, AND, pop to out3
        ui_in = 8'h05;
        repeat (2) @(negedge clk);
        send(8'h00);
        send(8'h02);
        check("push2_depth", stack_depth, 2);
        send(8'h98);
        check("and_tos", tos_out, 1);
        check("and_depth", stack_depth, 1);
        send(8'h13);
        check("pop_uo", uo_out, 8'h08);
        check("pop_depth", stack_depth, 0);
        check("pop_tos", tos_out, 0);

        // overflow then underflow, then software clears
        for (int i = 0; i < 8; i++) send(8'hBF);
        check("full_depth", stack_depth, 8);
        check("full_no_ovf", sfr_out[8], 0);
        send(8'hBF);
        check("ovf_depth", stack_depth, 8);
        check("ovf_sfr", sfr_out, 16'h0100);
        send(8'hF0);
        send(8'h10);
        check("unf_sfr", sfr_out, 16'h0300);
        check("unf_tos", tos_out, 0);
        check("unf_depth", stack_depth, 0);
        check("unf_uo", uo_out, 8'h08);
        send(8'hBF); send(8'h78);
        send(8'hBF); send(8'h79);
        check("flags_cleared", sfr_out, 16'h0000);

        // edge latching on ui_in[1]
        @(negedge clk); ui_in = 8'h07;
        @(negedge clk); ui_in = 8'h05;
        @(negedge clk);
        send(8'hC1);
        check("rise_first", tos_out, 1);
        send(8'hC1);
        check("rise_cleared", tos_out, 0);
        send(8'hD1);
        check("fall_first", tos_out, 1);
        send(8'hD1);
        check("fall_cleared", tos_out, 0);
        check("edge_depth", stack_depth, 4);
        send(8'hF0);

        // swap / rot / setall
        send(8'hBF); send(8'hB0);
        send(8'hF2);
        check("swap_tos", tos_out, 1);
        send(8'hF3); send(8'hF3);
        check("rot2_tos", tos_out, 0);
        send(8'hF3);
        check("rot3_tos", tos_out, 1);
        check("rot_depth", stack_depth, 2);
        send(8'hF1);
        check("setall_depth", stack_depth, 8);
        send(8'hF0);

        // conditional parameter writes on timer 1, routed to uo_out[6]
        send(8'hBF);
        send(8'hEA);
        check("param_pend", sfr_out[10], 1);
        send(8'h00);
        check("param_done", sfr_out[10], 0);
        check("param_consumed", stack_depth, 1);
        send(8'hEB); send(8'h02);
        send(8'h62);
        send(8'hBF); send(8'h6D);
        check("t1_en", sfr_out[2], 1);
        measure(6, n);
        check("t1_per2", n, 3);
        send(8'hEB); send(8'h05);
        check("cond_false_consumed", stack_depth, 0);
        measure(6, n);
        check("t1_unchanged", n, 3);
        send(8'hBF);
        send(8'hEB); send(8'h05);
        measure(6, n);
        check("t1_per5", n, 6);
        send(8'hEF); send(8'h01);
        measure(6, n);
        check("idx7_ignored", n, 6);

        // timer 0 routed to uo_out[7]
        send(8'hE8); send(8'h00);
        send(8'hE9); send(8'h02);
        send(8'h60);
        send(8'hBF); send(8'h6C);
        check("t0_en", sfr_out[0], 1);
        measure(7, n);
        check("t0_per2", n, 3);

        // reset while a parameter byte is pending
        send(8'hEA);
        check("pend_before_rst", sfr_out[10], 1);
        rst_n = 1'b0;
        #1;
        check("midparam_sfr", sfr_out, 0);
        check("midparam_uo", uo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'hBF);
        check("after_rst_exec", stack_depth, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
